// File: rtl/seed_cache_ctrl_if.sv
// seed_cache_ctrl_if: flush, lookup, fill and tag-RAM signals of the seed-cache controller.
interface seed_cache_ctrl_if #(
  parameter int AW = 7,
  parameter int TW = 20
);
  logic          flush_req;
  logic          flush_busy;
  logic          flush_done;
  logic          lk_req;
  logic [AW-1:0] lk_addr;
  logic [TW-1:0] lk_tag;
  logic          lk_gnt;
  logic          lk_valid;
  logic          lk_hit;
  logic          fill_req;
  logic [AW-1:0] fill_addr;
  logic [TW-1:0] fill_tag;
  logic          fill_gnt;
  logic [AW-1:0] tag_addr;
  logic          tag_we;
  logic [TW:0]   tag_wdata;
  logic [TW:0]   tag_rdata;
  modport master (
    output flush_req, lk_req, lk_addr, lk_tag, fill_req, fill_addr, fill_tag, tag_rdata,
    input  flush_busy, flush_done, lk_gnt, lk_valid, lk_hit, fill_gnt, tag_addr, tag_we, tag_wdata
  );
  modport slave (
    input  flush_req, lk_req, lk_addr, lk_tag, fill_req, fill_addr, fill_tag, tag_rdata,
    output flush_busy, flush_done, lk_gnt, lk_valid, lk_hit, fill_gnt, tag_addr, tag_we, tag_wdata
  );
endinterface

// File: rtl/seed_cache_ctrl.sv
// seed_cache_ctrl: seed-cache tag controller with invalidate-all sweep and lookup/fill arbitration.
// Define SEED_CACHE_CTRL_RR_EN for round-robin lookup/fill arbitration; default is fill-first.
module seed_cache_ctrl #(
  parameter int AW = 7,
  parameter int TW = 20
) (
  input logic clk,
  input logic rst,
  seed_cache_ctrl_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic          lk_v_q, lk_v_d;
  logic [TW-1:0] lk_tag_q, lk_tag_d;
  logic          idle_free, flushing, lk_gnt, fill_gnt, lk_pri;
`ifdef SEED_CACHE_CTRL_RR_EN
  logic last_fill_q, last_fill_d;
  assign lk_pri = last_fill_q;
  always_comb last_fill_d = fill_gnt ? 1'b1 : lk_gnt ? 1'b0 : last_fill_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_fill_q <= 1'b1;
    else last_fill_q <= last_fill_d;
`else
  assign lk_pri = 1'b0;
`endif
  always_comb begin
    flushing  = state_q == FLUSH;
    idle_free = !flushing && !bus.flush_req && !pend_q;
    fill_gnt  = idle_free && bus.fill_req && (!bus.lk_req || !lk_pri);
    lk_gnt    = idle_free && bus.lk_req && (!bus.fill_req || lk_pri);
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    if (!flushing) begin
      if (bus.flush_req || pend_q) begin
        state_d = FLUSH;
        pend_d  = 1'b0;
      end
    end else begin
      // decrementing past zero reloads the counter to all ones for the next sweep
      cnt_d  = cnt_q - AW'(1);
      pend_d = pend_q || bus.flush_req;
      if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    lk_v_d   = lk_gnt;
    lk_tag_d = lk_gnt ? bus.lk_tag : lk_tag_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '1;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      lk_v_q   <= 1'b0;
      lk_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      lk_v_q   <= lk_v_d;
      lk_tag_q <= lk_tag_d;
    end
  assign bus.flush_busy = flushing;
  assign bus.flush_done = done_q;
  assign bus.lk_gnt     = lk_gnt;
  assign bus.fill_gnt   = fill_gnt;
  assign bus.lk_valid   = lk_v_q;
  assign bus.lk_hit     = lk_v_q && bus.tag_rdata[TW] && (bus.tag_rdata[TW-1:0] == lk_tag_q);
  assign bus.tag_we     = flushing || fill_gnt;
  assign bus.tag_addr   = flushing ? cnt_q : fill_gnt ? bus.fill_addr : lk_gnt ? bus.lk_addr : '0;
  assign bus.tag_wdata  = fill_gnt ? {1'b1, bus.fill_tag} : '0;
endmodule

// File: doc/seed_cache_ctrl.md
SEED_CACHE_CTRL -- requirements
Module: seed_cache_ctrl

Interface
REQ-001 Parameter AW, default 7, meaning seed-cache index width (2^AW entries).
REQ-002 Parameter TW, default 20, meaning stored tag width; tag RAM word is TW+1 bits, MSB = valid bit.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush_req  input  1  invalidate-all request pulse (from l.end detect).
REQ-006 flush_busy  output  1  high while the flush sweep is writing.
REQ-007 flush_done  output  1  one-cycle pulse after the last flush write.
REQ-008 lk_req / lk_addr / lk_tag  input  1 / AW / TW  lookup request, index, compare tag.
REQ-009 lk_gnt  output  1  lookup accepted this cycle.
REQ-010 lk_valid / lk_hit  output  1 / 1  lookup result strobe and hit flag.
REQ-011 fill_req / fill_addr / fill_tag  input  1 / AW / TW  fill write request, index, tag.
REQ-012 fill_gnt  output  1  fill accepted (written) this cycle.
REQ-013 tag_addr / tag_we / tag_wdata  output  AW / 1 / TW+1  single-port synchronous tag RAM port.
REQ-014 tag_rdata  input  TW+1  RAM read data, valid one cycle after address.

Function
REQ-015 The block SHALL implement states IDLE, FLUSH, and a one-bit flush_pend latch.
REQ-016 In IDLE, flush_req or flush_pend SHALL move the state to FLUSH next cycle, clear flush_pend, and suppress all grants that cycle.
REQ-017 In FLUSH, tag_we=1, tag_wdata=0, tag_addr=cnt; cnt SHALL start at 2^AW-1 and decrement once per cycle down to 0 (exactly 2^AW writes).
REQ-018 After the write at cnt=0 the state SHALL return to IDLE, pulse flush_done for that next cycle, and reload cnt to all ones.
REQ-019 flush_req during FLUSH SHALL set flush_pend; a new sweep SHALL begin after flush_done with no other requester granted in between.
REQ-020 flush_busy SHALL equal (state==FLUSH); lk_gnt and fill_gnt SHALL be 0 in FLUSH.
REQ-021 In IDLE without flush, at most one of lk_gnt/fill_gnt SHALL be asserted; grant is combinational from the requests in the same cycle.
REQ-022 Fill grant: tag_addr=fill_addr, tag_we=1, tag_wdata={1'b1, fill_tag}.
REQ-023 Lookup grant: tag_addr=lk_addr, tag_we=0; lk_tag SHALL be registered at grant.
REQ-024 lk_valid SHALL assert exactly one cycle after lk_gnt, with lk_hit = tag_rdata[TW] AND (tag_rdata[TW-1:0] == registered lk_tag); lk_hit SHALL be 0 whenever lk_valid is 0.
REQ-025 A fill to index X followed by a lookup to X in a later cycle SHALL observe the filled tag.
REQ-026 With no grant and not flushing, tag_addr=0, tag_we=0, tag_wdata=0.
REQ-027 Requesters SHALL hold req until granted; the block SHALL NOT queue lookup or fill requests.

Reset
REQ-028 On rst: state=IDLE, cnt=all ones, flush_pend=0, lk_tag register=0, all outputs 0.
REQ-029 rst asserted mid-FLUSH SHALL abort the sweep with no flush_done pulse and discard flush_pend.
REQ-030 rst asserted the cycle after a lookup grant SHALL force lk_valid=0.

Configuration
REQ-031 Macro SEED_CACHE_CTRL_RR_EN: defined -> lookup/fill arbitration is round-robin (a one-bit last-winner register, reset to "fill", gives the other requester priority on conflict).
REQ-032 Without SEED_CACHE_CTRL_RR_EN: fixed priority, fill beats lookup on every conflict; no last-winner register exists.

Verification
REQ-033 Reset, flush_req pulse at cycle 0 (AW=7) -> flush_busy cycles 1-128, tag_addr 127..0 with we=1 data=0, flush_done at cycle 129.
REQ-034 flush_req pulses again during sweep at count 40 -> single second sweep of 128 writes after flush_done, no grants between sweeps.
REQ-035 fill idx 5 tag 0x1ABCD, then lookup idx 5 tag 0x1ABCD -> lk_valid one cycle after lk_gnt with lk_hit=1; lookup tag 0x1ABCE -> lk_hit=0.
REQ-036 Fill idx 5, flush, lookup idx 5 same tag -> lk_hit=0.
REQ-037 lk_req and fill_req held high together for 4 cycles -> with RR_EN grants alternate L,F,L,F; without RR_EN fill granted all 4 cycles.
REQ-038 rst asserted at cnt=60 of a sweep -> no flush_done, flush_busy=0 immediately, cnt all ones after release.
